// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// the canonical NOP, boolean aliases and the sequential-PC helper.
package fetch_stage_pkg;

  // Fetch controller states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    STALL = 2'd2
  } fetch_state_e;

  // addi x0, x0, 0 -- presented to decode whenever ir is not a real instruction
  localparam logic [31:0] NOP_INSN = 32'h0000_0013;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  // Next sequential fetch address; wraps naturally at the top of the 32-bit space
  function automatic logic [31:0] seq_pc(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a synchronous-read instruction
// memory and presents ir / ir_pc / ir_valid to decode. A one-entry skid
// register keeps the read that is in flight when decode stalls, and execute
// redirects flush everything younger than the target.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_8000,
  parameter int          IMEM_ADDR_W = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  output logic                   imem_en,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic [31:0]            ir,
  output logic [31:0]            ir_pc,
  output logic                   ir_valid
);

  fetch_state_e state_q, state_d;

  logic [31:0] pc_q, pc_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic        f_vld_q, f_vld_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        skid_vld_q, skid_vld_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] ir_pc_q, ir_pc_d;
  logic        ir_valid_q, ir_valid_d;

  logic        issue;
  logic [31:0] issue_pc;
  logic [31:0] redirect_tgt;

  // Targets are word aligned; the two low bits of the redirect address are ignored
  assign redirect_tgt = redirect_pc_i & ~32'h3;

  // Next-state and datapath control: redirect beats stall beats advance
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    f_pc_d     = f_pc_q;
    f_vld_d    = f_vld_q;
    skid_d     = skid_q;
    skid_pc_d  = skid_pc_q;
    skid_vld_d = skid_vld_q;
    ir_d       = ir_q;
    ir_pc_d    = ir_pc_q;
    ir_valid_d = ir_valid_q;
    issue      = FALSE;
    issue_pc   = pc_q;

    unique case (state_q)
      IDLE: begin
        state_d = RUN;
      end

      RUN, STALL: begin
        if (redirect_i) begin
          issue      = TRUE;
          issue_pc   = redirect_tgt;
          skid_vld_d = FALSE;
          ir_d       = NOP_INSN;
          ir_valid_d = FALSE;
          state_d    = RUN;
        end else if (stall_i) begin
          if (state_q == RUN) begin
            if (f_vld_q) begin
              skid_d     = imem_rdata;
              skid_pc_d  = f_pc_q;
              skid_vld_d = TRUE;
            end
            f_vld_d = FALSE;
            state_d = STALL;
          end
        end else if (state_q == RUN) begin
          issue      = TRUE;
          ir_d       = f_vld_q ? imem_rdata : NOP_INSN;
          ir_pc_d    = f_pc_q;
          ir_valid_d = f_vld_q;
        end else begin
          issue      = TRUE;
          ir_d       = skid_vld_q ? skid_q : NOP_INSN;
          ir_pc_d    = skid_pc_q;
          ir_valid_d = skid_vld_q;
          skid_vld_d = FALSE;
          state_d    = RUN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (issue) begin
      f_pc_d  = issue_pc;
      f_vld_d = TRUE;
      pc_d    = seq_pc(issue_pc);
    end
  end

  // All fetch state, including the registered decode-facing outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      f_pc_q     <= 32'h0;
      f_vld_q    <= FALSE;
      skid_q     <= 32'h0;
      skid_pc_q  <= 32'h0;
      skid_vld_q <= FALSE;
      ir_q       <= NOP_INSN;
      ir_pc_q    <= 32'h0;
      ir_valid_q <= FALSE;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      f_pc_q     <= f_pc_d;
      f_vld_q    <= f_vld_d;
      skid_q     <= skid_d;
      skid_pc_q  <= skid_pc_d;
      skid_vld_q <= skid_vld_d;
      ir_q       <= ir_d;
      ir_pc_q    <= ir_pc_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign imem_en   = issue;
  assign imem_addr = issue_pc[IMEM_ADDR_W+1:2];
  assign ir        = ir_q;
  assign ir_pc     = ir_pc_q;
  assign ir_valid  = ir_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage. The reference model is the architectural
// instruction stream: decode must consume consecutive word addresses starting
// at the reset PC or at the latest redirect target, each carrying the memory
// word at that address, with nothing dropped or repeated across stalls.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_8000;
  localparam int          AW       = 14;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          stall_i = 1'b0;
  logic          redirect_i = 1'b0;
  logic [31:0]   redirect_pc_i = 32'h0;
  logic          imem_en;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_rdata = 32'h0;
  logic [31:0]   ir;
  logic [31:0]   ir_pc;
  logic          ir_valid;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  logic [31:0] expQ[$];
  logic [31:0] genPc = RESET_PC;
  bit          prevRedirect = 1'b0;

  fetch_stage #(
    .RESET_PC   (RESET_PC),
    .IMEM_ADDR_W(AW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall_i      (stall_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .imem_en      (imem_en),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .ir           (ir),
    .ir_pc        (ir_pc),
    .ir_valid     (ir_valid)
  );

  always #5 clk = ~clk;

  // Memory image: every word is distinct and derived from its word address
  function automatic logic [31:0] memWord(input logic [AW-1:0] w);
    return {w, w, 4'h0} ^ 32'h1357_0013;
  endfunction

  function automatic logic [AW-1:0] wordOf(input logic [31:0] pc);
    return pc[AW+1:2];
  endfunction

  // Synchronous-read instruction memory, one cycle latency
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= memWord(imem_addr);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic refill();
    while (expQ.size() < 8) begin
      expQ.push_back(genPc);
      genPc = genPc + 32'd4;
    end
  endtask

  task automatic restartStream(input logic [31:0] pc);
    expQ.delete();
    genPc = pc & ~32'h3;
    refill();
  endtask

  // Drive one cycle of inputs just after the rising edge and update the expected stream
  task automatic applyStimulus(input bit st, input bit rd, input logic [31:0] tgt);
    @(posedge clk);
    #1;
    stall_i       = st;
    redirect_i    = rd;
    redirect_pc_i = tgt;
    if (rd) restartStream(tgt);
    else refill();
  endtask

  // Release reset just after a rising edge; the DUT spends that cycle in IDLE
  task automatic releaseReset();
    @(posedge clk);
    #1;
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    rst_n      = 1'b1;
    #1;
    checkOutput("idle_imem_en", {31'b0, imem_en}, 32'd0);
  endtask

  // Monitor: decode consumes ir whenever it is valid and neither stalled nor squashed
  always @(negedge clk) begin
    if (!rst_n) begin
      prevRedirect = 1'b0;
    end else begin
      if (!ir_valid) checkOutput("nop_when_invalid", ir, NOP_INSN);
      if (prevRedirect) checkOutput("invalid_after_redirect", {31'b0, ir_valid}, 32'd0);
      if (stall_i && !redirect_i) checkOutput("no_issue_on_stall", {31'b0, imem_en}, 32'd0);
      if (redirect_i) begin
        checkOutput("redirect_imem_en", {31'b0, imem_en}, 32'd1);
        checkOutput("redirect_imem_addr", {18'b0, imem_addr}, {18'b0, wordOf(redirect_pc_i)});
      end
      if (ir_valid && !stall_i && !redirect_i) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL stream_underflow: got pc %h expected none", ir_pc);
        end else begin
          logic [31:0] expPc;
          expPc = expQ.pop_front();
          checkOutput("stream_pc", ir_pc, expPc);
          checkOutput("stream_insn", ir, memWord(wordOf(expPc)));
          delivered++;
        end
      end
      prevRedirect = redirect_i;
    end
  end

  // Directed scenarios, then a randomized stall/redirect mix, then a throughput drain
  initial begin
    int d0;
    restartStream(RESET_PC);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_imem_en", {31'b0, imem_en}, 32'd0);
    checkOutput("reset_ir_valid", {31'b0, ir_valid}, 32'd0);
    checkOutput("reset_ir", ir, NOP_INSN);
    checkOutput("reset_ir_pc", ir_pc, 32'd0);

    // Startup latency: first issue in cycle 1, first valid instruction in cycle 3
    releaseReset();
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("first_issue_en", {31'b0, imem_en}, 32'd1);
    checkOutput("first_issue_addr", {18'b0, imem_addr}, {18'b0, wordOf(RESET_PC)});
    checkOutput("c1_ir_valid", {31'b0, ir_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("c2_ir_valid", {31'b0, ir_valid}, 32'd0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("c3_ir_valid", {31'b0, ir_valid}, 32'd1);
    checkOutput("c3_ir_pc", ir_pc, 32'h0000_8000);

    // Stall for three cycles while 0x8008 is in flight
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 32'h0);
      checkOutput("stall_ir_pc_frozen", ir_pc, 32'h0000_8004);
    end
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("release_ir_pc", ir_pc, 32'h0000_8004);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("after_release_pc", ir_pc, 32'h0000_8008);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("after_release_pc2", ir_pc, 32'h0000_800C);

    // Plain redirect
    applyStimulus(1'b0, 1'b1, 32'h0000_8100);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redir_ir_valid", {31'b0, ir_valid}, 32'd0);
    checkOutput("redir_ir_nop", ir, NOP_INSN);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redir_target_pc", ir_pc, 32'h0000_8100);
    checkOutput("redir_target_valid", {31'b0, ir_valid}, 32'd1);

    // Redirect together with stall, first while running, then while stalled
    applyStimulus(1'b1, 1'b1, 32'h0000_8102);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redir_stall_run_pc", ir_pc, 32'h0000_8100);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'h0000_8200);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redir_stall_stall_pc", ir_pc, 32'h0000_8200);

    // Address wrap at the top of memory space
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("wrap_pc_top", ir_pc, 32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("wrap_pc_zero", ir_pc, 32'h0000_0000);

    // Asynchronous reset in the middle of a stall
    applyStimulus(1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_ir_valid", {31'b0, ir_valid}, 32'd0);
    checkOutput("async_rst_ir", ir, NOP_INSN);
    checkOutput("async_rst_imem_en", {31'b0, imem_en}, 32'd0);
    stall_i    = 1'b0;
    redirect_i = 1'b0;
    restartStream(RESET_PC);
    releaseReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("refetch_pc", ir_pc, RESET_PC);

    // Randomized mix of stalls and redirects
    for (int i = 0; i < 600; i++) begin
      bit          st;
      bit          rd;
      logic [31:0] tgt;
      st = ($urandom_range(99, 0) < 30);
      rd = ($urandom_range(99, 0) < 8);
      case ($urandom_range(3, 0))
        0: tgt = 32'hFFFF_FFF8 | {30'b0, 2'($urandom_range(3, 0))};
        1: tgt = RESET_PC + 32'($urandom_range(255, 0));
        default: tgt = $urandom;
      endcase
      applyStimulus(st, rd, tgt);
    end

    // Free-running drain: one instruction per cycle once the pipe refills
    d0 = delivered;
    for (int i = 0; i < 25; i++) applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    checkOutput("throughput", {31'b0, (delivered - d0) >= 22}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
